// File: rtl/ht_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | ht_pkg : MPEG-1 Layer III Huffman table 5 constants and FSM states     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ht_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CODE  = 2'd1,
    SIGNX = 2'd2,
    SIGNY = 2'd3
  } ht_state_e;

  // Indexed by {x[1:0], y[1:0]}; codes right-aligned
  localparam logic [7:0] HT5_HCOD [16] = '{
    8'h01, 8'h02, 8'h06, 8'h05,
    8'h03, 8'h01, 8'h04, 8'h04,
    8'h07, 8'h05, 8'h07, 8'h01,
    8'h06, 8'h01, 8'h01, 8'h00
  };

  localparam logic [3:0] HT5_HLEN [16] = '{
    4'd1, 4'd3, 4'd6, 4'd7,
    4'd3, 4'd3, 4'd6, 4'd7,
    4'd6, 4'd6, 4'd7, 4'd8,
    4'd7, 4'd6, 4'd7, 4'd8
  };

  function automatic logic [3:0] mag4(input logic [3:0] v, input logic is_signed);
    return (is_signed && v[3]) ? (~v + 4'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ht5_code_lut.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | ht5_code_lut : table-5 codeword lookup, left-aligned code + length     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ht5_code_lut
  import ht_pkg::*;
(
  input  logic [3:0] x_mag_i,
  input  logic [3:0] y_mag_i,
  output logic [7:0] code_o,
  output logic [3:0] len_o,
  output logic       in_range_o
);

  logic [3:0] idx;

  assign idx        = {x_mag_i[1:0], y_mag_i[1:0]};
  assign in_range_o = (x_mag_i[3:2] == 2'b00) && (y_mag_i[3:2] == 2'b00);
  assign len_o      = HT5_HLEN[idx];
  // Left-align so the shifter always emits from bit 7
  assign code_o     = HT5_HCOD[idx] << (4'd8 - HT5_HLEN[idx]);

endmodule
`default_nettype wire

// File: rtl/ht5_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | ht5_encoder : serial Huffman table-5 encoder with optional sign bits   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ht5_encoder
  import ht_pkg::*;
#(
  parameter int SIGN_BITS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [3:0] x_val,
  input  logic [3:0] y_val,
  output logic       axiir,
  output logic       axiov,
  output logic       axiod,
  output logic       axiol,
  output logic       err
);

  localparam logic SB = (SIGN_BITS != 0);

  ht_state_e  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] cnt_q, cnt_d;
  logic       xneg_q, xneg_d, yneg_q, yneg_d;
  logic       xnz_q, xnz_d, ynz_q, ynz_d;
  logic       err_q, err_d;

  logic [3:0] x_mag, y_mag;
  logic [7:0] lut_code;
  logic [3:0] lut_len;
  logic       lut_ok;
  logic       last_bit;
  logic       accept;

  assign x_mag = mag4(x_val, SB);
  assign y_mag = mag4(y_val, SB);

  ht5_code_lut u_lut (
    .x_mag_i    (x_mag),
    .y_mag_i    (y_mag),
    .code_o     (lut_code),
    .len_o      (lut_len),
    .in_range_o (lut_ok)
  );

  // xnz/ynz are held low when signs are disabled, so CODE always ends the pair
  always_comb begin
    case (state_q)
      CODE:    last_bit = (cnt_q == 4'd1) && !(xnz_q || ynz_q);
      SIGNX:   last_bit = !ynz_q;
      SIGNY:   last_bit = 1'b1;
      default: last_bit = 1'b0;
    endcase
  end

  assign axiir  = (state_q == IDLE) || last_bit;
  assign accept = axiiv && axiir;
  assign axiov  = (state_q != IDLE);
  assign axiol  = last_bit;
  assign err    = err_q;

  always_comb begin
    case (state_q)
      CODE:    axiod = shreg_q[7];
      SIGNX:   axiod = xneg_q;
      SIGNY:   axiod = yneg_q;
      default: axiod = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    xneg_d  = xneg_q;
    yneg_d  = yneg_q;
    xnz_d   = xnz_q;
    ynz_d   = ynz_q;
    err_d   = 1'b0;
    case (state_q)
      CODE: begin
        shreg_d = {shreg_q[6:0], 1'b0};
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (xnz_q)      state_d = SIGNX;
          else if (ynz_q) state_d = SIGNY;
          else            state_d = IDLE;
        end
      end
      SIGNX:   state_d = ynz_q ? SIGNY : IDLE;
      SIGNY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accept only happens in IDLE or on a final bit, so it overrides the above
    if (accept) begin
      if (lut_ok) begin
        state_d = CODE;
        shreg_d = lut_code;
        cnt_d   = lut_len;
        xneg_d  = SB && x_val[3];
        yneg_d  = SB && y_val[3];
        xnz_d   = SB && (x_val != 4'd0);
        ynz_d   = SB && (y_val != 4'd0);
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= 8'd0;
      cnt_q   <= 4'd0;
      xneg_q  <= 1'b0;
      yneg_q  <= 1'b0;
      xnz_q   <= 1'b0;
      ynz_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      xneg_q  <= xneg_d;
      yneg_q  <= yneg_d;
      xnz_q   <= xnz_d;
      ynz_q   <= ynz_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ht5_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ht5_encoder : scoreboard bench for ht5_encoder (both sign modes)    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ht5_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] x_val = 4'd0;
  logic [3:0] y_val = 4'd0;

  logic ir0, ov0, od0, ol0, er0;
  logic ir1, ov1, od1, ol1, er1;
  logic ir_m, ov_m, od_m, ol_m, er_m;

  ht5_encoder #(.SIGN_BITS(0)) u_dut0 (
    .clk(clk), .rst(rst), .axiiv(axiiv & ~sel), .x_val(x_val), .y_val(y_val),
    .axiir(ir0), .axiov(ov0), .axiod(od0), .axiol(ol0), .err(er0)
  );

  ht5_encoder #(.SIGN_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .axiiv(axiiv & sel), .x_val(x_val), .y_val(y_val),
    .axiir(ir1), .axiov(ov1), .axiod(od1), .axiol(ol1), .err(er1)
  );

  assign ir_m = sel ? ir1 : ir0;
  assign ov_m = sel ? ov1 : ov0;
  assign od_m = sel ? od1 : od0;
  assign ol_m = sel ? ol1 : ol0;
  assign er_m = sel ? er1 : er0;

  always #5 clk = ~clk;

  typedef struct {
    bit    is_err;
    string bits;
  } exp_t;

  string CODES [16] = '{
    "1",       "010",    "000110",  "0000101",
    "011",     "001",    "000100",  "0000100",
    "000111",  "000101", "0000111", "00000001",
    "0000110", "000001", "0000001", "00000000"
  };

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    nbits  = 0;
  string acc    = "";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input bit sb);
    exp_t e;
    int ax, ay;
    e.is_err = 1'b0;
    e.bits   = "";
    if (x < -3 || x > 3 || y < -3 || y > 3 || (!sb && (x < 0 || y < 0))) begin
      e.is_err = 1'b1;
      return e;
    end
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    e.bits = CODES[ax*4 + ay];
    if (sb && x != 0) begin
      if (x < 0) e.bits = {e.bits, "1"}; else e.bits = {e.bits, "0"};
    end
    if (sb && y != 0) begin
      if (y < 0) e.bits = {e.bits, "1"}; else e.bits = {e.bits, "0"};
    end
    return e;
  endfunction

  task automatic send(input int x, input int y);
    int g;
    @(negedge clk);
    axiiv = 1'b1;
    x_val = x[3:0];
    y_val = y[3:0];
    g = 0;
    while (!ir_m && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("ready_timeout", 32'd1, 32'd0);
    exp_q.push_back(model(x, y, sel));
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    axiiv = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Output monitor / scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        acc = "";
      end else begin
        if (!ov_m) chk("od_when_idle", {31'd0, od_m}, 32'd0);
        if (er_m) begin
          chk("err_with_ov", {31'd0, ov_m}, 32'd0);
          if (exp_q.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("err_expected", 32'd1, {31'd0, e.is_err});
          end
        end
        if (ov_m) begin
          nbits++;
          chk("axiir_eq_axiol", {31'd0, ir_m}, {31'd0, ol_m});
          if (od_m) acc = {acc, "1"}; else acc = {acc, "0"};
          if (ol_m) begin
            if (exp_q.size() == 0) chk("pair_unexpected", 32'd1, 32'd0);
            else begin
              e = exp_q.pop_front();
              checks++;
              assert (!e.is_err && acc == e.bits) else begin
                errors++;
                $error("FAIL pair_bits observed=%s expected=%s (err_exp=%0d)", acc, e.bits, e.is_err);
              end
            end
            acc = "";
          end
        end else if (acc.len() != 0) begin
          checks++;
          errors++;
          $error("FAIL gap_in_pair observed=%s expected=contiguous", acc);
          acc = "";
        end
      end
    end
  end

  initial begin
    int n0;
    int rx, ry;

    repeat (3) @(negedge clk);
    chk("rst_axiir", {31'd0, ir0}, 32'd1);
    chk("rst_axiov", {31'd0, ov0}, 32'd0);
    chk("rst_axiod", {31'd0, od0}, 32'd0);
    chk("rst_axiol", {31'd0, ol0}, 32'd0);
    chk("rst_err",   {31'd0, er0}, 32'd0);
    chk("rst_axiir1", {31'd0, ir1}, 32'd1);
    rst = 1'b1;

    // Unsigned back-to-back stream
    sel = 1'b0;
    send(1, 1); send(0, 2); send(0, 3); send(0, 1);
    go_idle(); drain();
    send(0, 0); send(3, 3); send(2, 3);
    go_idle(); drain();
    send(4, 0); send(1, 0);
    go_idle(); drain();
    send(15, 2); send(3, 1);
    go_idle(); drain();

    // Signed mode
    sel = 1'b1;
    send(-1, 0); send(2, -3); send(-5, 0); send(3, -3); send(0, 1);
    go_idle(); drain();

    // Asynchronous reset during bit 4 of (2,3)
    sel = 1'b0;
    send(2, 3);
    go_idle();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst_axiov", {31'd0, ov0}, 32'd0);
    chk("async_rst_axiol", {31'd0, ol0}, 32'd0);
    chk("async_rst_axiir", {31'd0, ir0}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n0 = nbits;
    send(0, 1);
    go_idle(); drain();
    repeat (10) @(negedge clk);
    chk("post_rst_bitcount", nbits - n0, 32'd3);

    // Continuous random signed in-range stream
    sel = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rx = int'($urandom_range(0, 6)) - 3;
      ry = int'($urandom_range(0, 6)) - 3;
      send(rx, ry);
    end
    go_idle(); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ht5_encoder.md
Name: ht5_encoder

Overview:
- Huffman encoder for MPEG-1 Layer III big-values table 5, the transmit-side counterpart of the table-5 serial decoder.
- Accepts one (x,y) quantized pair per handshake and emits the codeword serially, MSB first, one bit per cycle.
- Optionally appends the x and y sign bits after the codeword.
- Used to generate bitstreams for decoder loopback tests and for the encoder path.

Parameters:
- SIGN_BITS, 0, 1 = append sign bits (x first, then y) for nonzero values and treat inputs as signed; 0 = unsigned inputs, no sign bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- axiiv  in  1  input pair valid
- x_val  in  4  x value (two's complement if SIGN_BITS=1, else unsigned)
- y_val  in  4  y value, same encoding as x_val
- axiir  out  1  ready; a pair is accepted on any cycle with axiiv & axiir
- axiov  out  1  serial output bit valid
- axiod  out  1  serial output bit
- axiol  out  1  high with the last bit of the current pair
- err  out  1  one-cycle pulse: the accepted pair was out of range

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; axiov=0, axiod=0, axiol=0, err=0, axiir=1.
  - Any partial codeword in flight is abandoned.
  - Outputs resume only after a new accept.
- Code table, indexed by (x,y) as hcod/len:
  - row x=0: 1/1, 010/3, 000110/6, 0000101/7
  - row x=1: 011/3, 001/3, 000100/6, 0000100/7
  - row x=2: 000111/6, 000101/6, 0000111/7, 00000001/8
  - row x=3: 0000110/7, 000001/6, 0000001/7, 00000000/8
- Range check:
  - A value is in range if its magnitude is 0..3.
  - With SIGN_BITS=0, values 4..15 are illegal.
  - With SIGN_BITS=1, -8..-4 and 4..7 are illegal.
- States:
  - IDLE: axiir=1. On accept:
    - in range: load code into the 8-bit shift register, load len into the bit counter, go to CODE;
    - out of range: err=1 on the next cycle, no bits emitted, stay in IDLE.
  - CODE: each cycle axiov=1, axiod=shift MSB, shift left, decrement count. After the last code bit:
    - go to SIGNX if SIGN_BITS and x≠0;
    - else go to SIGNY if SIGN_BITS and y≠0;
    - else the pair is done.
  - SIGNX: axiod = x sign (1 = negative); then go to SIGNY if y≠0, else the pair is done.
  - SIGNY: axiod = y sign; the pair is done.
- Latency: the first bit appears on axiov the cycle after acceptance.
- Bits of a pair are contiguous: no gaps.
- axiol is asserted with the final emitted bit of the pair, whether that is a code bit or a sign bit.
- axiir is high in IDLE and during the final-bit cycle. A pair accepted on the final-bit cycle starts on the next cycle, so back-to-back pairs form a gapless stream.
- An out-of-range pair accepted during the final-bit cycle:
  - err pulses on the next cycle with axiov=0;
  - the block returns to IDLE.
- axiod=0 whenever axiov=0.
- Inputs are sampled only at accept; changes to x_val/y_val mid-emission have no effect.
- err and axiov are never high in the same cycle.

Decomposition:
- Package ht_pkg holds:
  - HT5_HCOD[16] (8-bit codes, right-aligned);
  - HT5_HLEN[16] (4-bit lengths);
  - the state enum {IDLE, CODE, SIGNX, SIGNY}.
- Table index = {x[1:0], y[1:0]}.
- Sub-module ht5_code_lut: purely combinational. Inputs x, y magnitudes; outputs left-aligned 8-bit code, length, and in_range.
- The top module owns the FSM, shift register, counter and sign logic.

Test Plan:
- SIGN_BITS=0, pairs (1,1),(0,2),(0,3),(0,1) presented back-to-back:
  - 19 contiguous bits 0010001100000101010;
  - axiol on bits 3, 9, 16, 19;
  - axiir high only on those final-bit cycles.
- Pair (0,0) -> single bit 1 with axiol; pair (3,3) -> 00000000 with axiol on bit 8; pair (2,3) -> 00000001.
- x_val=4, y_val=0 -> err pulse one cycle after accept, axiov stays 0; the following (1,0) encodes as 011 normally.
- SIGN_BITS=1:
  - (-1,0) -> 011 then 1 (4 bits, axiol on bit 4);
  - (2,-3) -> 00000001 then 0,1 (10 bits);
  - (-5,0) -> err.
- Drive rst low during bit 4 of (2,3) -> axiov=0 asynchronously. After release, (0,1) yields exactly 010 with no residual bits.
- Hold axiiv=1 continuously with random in-range pairs for 200 pairs. Feed the output into the table-5 decoder; decoded x/y must match the sequence with no gaps and no err.
